// File: rtl/seg_scan_pkg.sv
// Shared constants for the eight-digit seven-segment scan controller:
// the segment decode table, the "all off" patterns and the digit index width.
package seg_scan_pkg;

  localparam int IDX_W = 3;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEL_OFF = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}, indexed by nibble value; dp is left dark here.
  localparam logic [7:0] SEG_TABLE [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side write port of the scan controller: buffer write strobe/data and
// the pending-buffer status fed back to the host.
interface seg_scan_ctrl_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp;
  logic        pend;

  modport master (output wr_en, output wr_data, output wr_dp, input pend);
  modport slave  (input wr_en, input wr_data, input wr_dp, output pend);
endinterface

// File: rtl/seg_scan_ctrl_seg7_dec.sv
// Combinational hex nibble + decimal point to active-low segment byte.
module seg7_dec
  import seg_scan_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] pat_s;

  // Table lookup, then the dp segment is lit (driven low) on request.
  always_comb begin
    pat_s = SEG_TABLE[nib];
    seg   = {~dp, pat_s[6:0]};
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scanner with double-buffered display data,
// per-slot anti-ghost blanking and optional leading-zero suppression.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 2
) (
  input  logic             clks,
  input  logic             rst,
  seg_scan_ctrl_if.slave   host,
  input  logic             lz_en,
  output logic [7:0]       digit_sel,
  output logic [7:0]       seg,
  output logic             frame_done
);

  localparam int            CW        = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);

  logic [CW-1:0]    cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic [31:0]      act_data_r;
  logic [7:0]       act_dp_r;
  logic [31:0]      pend_data_r;
  logic [7:0]       pend_dp_r;
  logic             pend_r;
  logic [7:0]       sel_r;
  logic [7:0]       seg_r;
  logic             frame_done_r;

  logic             slot_end_s;
  logic             boundary_s;
  logic             blank_s;
  logic             supp_s;
  logic [8:0]       zero_from_s;
  logic [3:0]       nib_s;
  logic             dp_s;
  logic [7:0]       dec_s;
  logic [7:0]       seg_next_s;

  // Slot position decode and selection of the digit currently being scanned.
  always_comb begin
    slot_end_s = (cnt_r == CNT_LAST);
    boundary_s = slot_end_s && (idx_r == IDX_LAST);
    blank_s    = (cnt_r < CNT_BLANK);
    nib_s      = act_data_r[{idx_r, 2'b00} +: 4];
    dp_s       = act_dp_r[idx_r];
  end

  // zero_from_s[i] is set when nibbles i..7 of the active buffer are all zero.
  always_comb begin
    zero_from_s    = 9'd0;
    zero_from_s[8] = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      zero_from_s[i] = zero_from_s[i+1] && (act_data_r[4*i +: 4] == 4'd0);
    end
  end

  seg7_dec u_dec (
    .nib (nib_s),
    .dp  (dp_s),
    .seg (dec_s)
  );

  // A suppressed digit stays selected but dark; only its dp may still light.
  always_comb begin
    supp_s = lz_en && (idx_r != IDX_W'(0)) && zero_from_s[idx_r];
    if (supp_s) begin
      seg_next_s = {~dp_s, SEG_OFF[6:0]};
    end else begin
      seg_next_s = dec_s;
    end
  end

  // Scan counters, buffer swap at the frame boundary and registered pin drive.
  always_ff @(posedge clks) begin
    if (rst) begin
      cnt_r        <= '0;
      idx_r        <= '0;
      act_data_r   <= 32'd0;
      act_dp_r     <= 8'd0;
      pend_data_r  <= 32'd0;
      pend_dp_r    <= 8'd0;
      pend_r       <= 1'b0;
      sel_r        <= SEL_OFF;
      seg_r        <= SEG_OFF;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= boundary_s;

      if (slot_end_s) begin
        cnt_r <= '0;
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end

      // A write landing on the boundary bypasses the pending buffer entirely.
      if (boundary_s) begin
        if (host.wr_en) begin
          act_data_r <= host.wr_data;
          act_dp_r   <= host.wr_dp;
        end else if (pend_r) begin
          act_data_r <= pend_data_r;
          act_dp_r   <= pend_dp_r;
        end else begin
          act_data_r <= act_data_r;
          act_dp_r   <= act_dp_r;
        end
        pend_r <= 1'b0;
      end else if (host.wr_en) begin
        pend_data_r <= host.wr_data;
        pend_dp_r   <= host.wr_dp;
        pend_r      <= 1'b1;
      end else begin
        pend_r <= pend_r;
      end

      if (blank_s) begin
        sel_r <= SEL_OFF;
        seg_r <= SEG_OFF;
      end else begin
        sel_r <= ~(8'b1 << idx_r);
        seg_r <= seg_next_s;
      end
    end
  end

  assign digit_sel  = sel_r;
  assign seg        = seg_r;
  assign frame_done = frame_done_r;
  assign host.pend  = pend_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIV=4, BLANK=1): directed steps plus
// randomized writes, compared every cycle against a frame-time reference model.
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 8 * DIV;

  logic       clks;
  logic       rst;
  logic       lz_en;
  logic [7:0] digit_sel;
  logic [7:0] seg;
  logic       frame_done;

  seg_scan_ctrl_if hif ();

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clks       (clks),
    .rst        (rst),
    .host       (hif.slave),
    .lz_en      (lz_en),
    .digit_sel  (digit_sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial clks = 1'b0;
  always #5 clks = ~clks;

  int total = 0;
  int bad   = 0;

  logic [7:0] dec_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Model state: elapsed cycles within the frame, buffers, expected outputs.
  int          m_t;
  logic [31:0] m_act, m_pdat;
  logic [7:0]  m_adp, m_pdp;
  logic        m_pend;
  logic [7:0]  e_sel, e_seg;
  logic        e_fd, e_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] ref_seg(logic [31:0] d, logic [7:0] dp, int i, logic lz);
    logic [7:0]  s;
    logic [31:0] above;
    above = d >> (4 * i);
    if (lz && i != 0 && above == 32'd0) s = 8'hFF;
    else                                s = dec_tab[above[3:0]];
    if (dp[i]) s[7] = 1'b0;
    return s;
  endfunction

  // One clock: predict the edge from the model, clock it, compare at negedge.
  task automatic step();
    int  idx, cnt;
    bit  bnd;
    if (rst) begin
      m_t = 0; m_act = 32'd0; m_adp = 8'd0; m_pdat = 32'd0; m_pdp = 8'd0; m_pend = 1'b0;
      e_sel = 8'hFF; e_seg = 8'hFF; e_fd = 1'b0;
    end else begin
      idx = m_t / DIV;
      cnt = m_t % DIV;
      bnd = (m_t == FRAME - 1);
      e_fd = bnd;
      if (cnt < BLANK) begin
        e_sel = 8'hFF; e_seg = 8'hFF;
      end else begin
        e_sel = ~(8'd1 << idx);
        e_seg = ref_seg(m_act, m_adp, idx, lz_en);
      end
      if (bnd) begin
        if (hif.wr_en)   begin m_act = hif.wr_data; m_adp = hif.wr_dp; end
        else if (m_pend) begin m_act = m_pdat;      m_adp = m_pdp;     end
        m_pend = 1'b0;
      end else if (hif.wr_en) begin
        m_pdat = hif.wr_data; m_pdp = hif.wr_dp; m_pend = 1'b1;
      end
      m_t = (m_t + 1) % FRAME;
    end
    e_pend = m_pend;
    @(posedge clks);
    @(negedge clks);
    check("digit_sel", {24'd0, digit_sel}, {24'd0, e_sel});
    check("seg", {24'd0, seg}, {24'd0, e_seg});
    check("pend", {31'd0, hif.pend}, {31'd0, e_pend});
    check("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
  endtask

  task automatic write(input logic [31:0] d, input logic [7:0] dp);
    hif.wr_en = 1'b1; hif.wr_data = d; hif.wr_dp = dp;
    step();
    hif.wr_en = 1'b0;
  endtask

  // Advance until the edge about to happen is the one at (i,c).
  task automatic goto_pre(input int i, input int c);
    for (int k = 0; k < 2 * FRAME && m_t != i * DIV + c; k++) step();
    check("goto", m_t, i * DIV + c);
  endtask

  // Advance so the outputs now shown correspond to slot position (i,c).
  task automatic show(input int i, input int c);
    goto_pre(i, c);
    step();
  endtask

  logic [7:0] f1_sel [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] f1_seg [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  logic [7:0] lz_seg [8] = '{8'h92, 8'hC0, 8'h79, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    int fd_cnt;
    rst = 1'b1; lz_en = 1'b0;
    hif.wr_en = 1'b0; hif.wr_data = 32'd0; hif.wr_dp = 8'd0;
    @(negedge clks);
    for (int k = 0; k < 3; k++) step();
    check("reset_sel", {24'd0, digit_sel}, 32'hFF);

    rst = 1'b0;
    step();
    check("first_blank_sel", {24'd0, digit_sel}, 32'hFF);
    step();
    check("first_sel", {24'd0, digit_sel}, 32'hFE);
    check("first_seg", {24'd0, seg}, 32'hC0);

    // Mid-frame write: current frame keeps showing zeros.
    goto_pre(2, 2);
    write(32'h12345678, 8'h00);
    check("pend_after_write", {31'd0, hif.pend}, 32'd1);
    show(5, 2);
    check("old_frame_seg", {24'd0, seg}, 32'hC0);
    for (int i = 0; i < 8; i++) begin
      show(i, 0);
      check("f1_gap_seg", {24'd0, seg}, 32'hFF);
      step();
      check("f1_sel", {24'd0, digit_sel}, {24'd0, f1_sel[i]});
      check("f1_seg", {24'd0, seg}, {24'd0, f1_seg[i]});
    end

    fd_cnt = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (frame_done) fd_cnt++;
    end
    check("frame_done_per_frame", fd_cnt, 1);

    // Leading-zero suppression.
    lz_en = 1'b1;
    goto_pre(1, 2);
    write(32'h00000105, 8'h04);
    for (int i = 0; i < 8; i++) begin
      show(i, 1);
      check("lz_seg", {24'd0, seg}, {24'd0, lz_seg[i]});
    end
    goto_pre(3, 0);
    write(32'h00000000, 8'h00);
    show(0, 2);
    check("lz_zero_d0", {24'd0, seg}, 32'hC0);
    show(3, 2);
    check("lz_zero_d3_seg", {24'd0, seg}, 32'hFF);
    check("lz_zero_d3_sel", {24'd0, digit_sel}, 32'hF7);
    lz_en = 1'b0;

    // Last write wins.
    goto_pre(1, 0);
    write(32'h11111111, 8'h00);
    step();
    write(32'h22222222, 8'h00);
    show(0, 1);
    check("last_write_wins", {24'd0, seg}, 32'hA4);

    // Write exactly on the boundary while a pending value waits.
    goto_pre(2, 1);
    write(32'h55555555, 8'h00);
    goto_pre(7, DIV - 1);
    write(32'h33333333, 8'h00);
    check("bnd_write_pend", {31'd0, hif.pend}, 32'd0);
    show(0, 1);
    check("bnd_write_seg", {24'd0, seg}, 32'hB0);

    // Randomized writes and suppression toggling.
    for (int k = 0; k < 400; k++) begin
      lz_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        logic [31:0] d;
        d = $urandom;
        d = d >> (4 * $urandom_range(0, 7));
        write(d, 8'($urandom));
      end else begin
        step();
      end
    end

    // Reset mid-frame.
    lz_en = 1'b0;
    goto_pre(4, 2);
    write(32'h9ABCDEF0, 8'hFF);
    goto_pre(4, 2);
    rst = 1'b1;
    step();
    check("midrst_sel", {24'd0, digit_sel}, 32'hFF);
    check("midrst_seg", {24'd0, seg}, 32'hFF);
    rst = 1'b0;
    step();
    step();
    check("resume_sel", {24'd0, digit_sel}, 32'hFE);
    check("resume_seg", {24'd0, seg}, 32'hC0);
    show(5, 3);
    check("resume_d5_seg", {24'd0, seg}, 32'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
